// File: rtl/gate_tt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_tt_sequencer
// Purpose  : Sweeps a 2-input combinational gate through all four input
//            vectors ({a,b} = 00, 01, 10, 11). Each vector is held for SETTLE
//            cycles and then sampled for one cycle. Each sample is compared
//            with an expected truth table that is latched when the sweep
//            starts. The block reports a per-vector fail mask and a pass flag.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  begin a sweep (honoured only while idle)
//   exp_tt     in   4  expected gate output, bit i for {a,b}=i
//   gate_a     out  1  registered drive to gate input a
//   gate_b     out  1  registered drive to gate input b
//   gate_o     in   1  gate output under test
//   busy       out  1  sweep in progress (drive/sample phases)
//   done       out  1  one-cycle completion pulse
//   pass       out  1  last completed sweep had no mismatch
//   fail_mask  out  4  per-vector mismatch flags
//   step       out  2  current vector index
// ============================================================================
module gate_tt_sequencer #(
  parameter int SETTLE = 2,  // cycles each vector is held before sampling (1..15)
  parameter int CNT_W  = 4   // settle counter width, must hold SETTLE-1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] exp_tt,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] step
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       exp_lat;
  logic             miss;
  logic [3:0]       mask_upd;

  // The fail mask as it will look after the current sample. The sample for
  // vector 3 and the pass flag are written on the same edge. For that reason
  // pass is derived from this updated mask and not from the stored one.
  always_comb begin
    miss           = gate_o ^ exp_lat[step];
    mask_upd       = fail_mask;
    mask_upd[step] = miss;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      exp_lat   <= '0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      step      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_lat   <= exp_tt;
            fail_mask <= '0;
            pass      <= 1'b0;
            step      <= '0;
            cnt       <= '0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            state     <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          if (cnt == CNT_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SAMPLE: begin
          fail_mask <= mask_upd;
          if (step == 2'd3) begin
            pass            <= ~|mask_upd;
            step            <= '0;
            {gate_a, gate_b} <= 2'b00;
            state           <= ST_DONE;
          end else begin
            // The gate drive advances together with step. This keeps
            // {gate_a,gate_b} equal to step for the whole of the next vector.
            step            <= step + 2'd1;
            {gate_a, gate_b} <= step + 2'd1;
            cnt             <= '0;
            state           <= ST_DRIVE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Both flags are decoded from registered state only, so start has no
  // combinational path to them.
  assign busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);

endmodule
`default_nettype wire
